// File: rtl/swo_uart_rx_pkg.sv
// Shared constants for the SWO UART receiver: FSM encodings, divisor floor and a vote helper.
package swo_uart_rx_pkg;

  localparam logic [2:0] SWO_ST_IDLE      = 3'd0;
  localparam logic [2:0] SWO_ST_START     = 3'd1;
  localparam logic [2:0] SWO_ST_DATA      = 3'd2;
  localparam logic [2:0] SWO_ST_STOP      = 3'd3;
  localparam logic [2:0] SWO_ST_WAIT_IDLE = 3'd4;

  localparam int SWO_MIN_DIV = 3;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/swo_line_filter.sv
// SWO pin conditioning: 2-FF synchronizer, plus a registered 2-of-3 majority vote
// when SWO_GLITCH_FILTER_EN is defined. All flops reset to the idle-high level.
module swo_line_filter (
  input  logic fe_clk,
  input  logic reset,
  input  logic I_swo,
  output logic line
);

  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge fe_clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= I_swo;
      sync2_r <= sync1_r;
    end
  end

`ifdef SWO_GLITCH_FILTER_EN
  import swo_uart_rx_pkg::*;

  logic hist1_r;
  logic hist2_r;
  logic filt_r;

  // Vote over the three most recent samples so a lone spike never reaches the line value.
  always_ff @(posedge fe_clk) begin
    if (reset) begin
      hist1_r <= 1'b1;
      hist2_r <= 1'b1;
      filt_r  <= 1'b1;
    end else begin
      hist1_r <= sync2_r;
      hist2_r <= hist1_r;
      filt_r  <= majority3(sync2_r, hist1_r, hist2_r);
    end
  end

  assign line = filt_r;
`else
  assign line = sync2_r;
`endif

endmodule

// File: rtl/swo_uart_rx.sv
// 8N1 receiver for the SWO pin with runtime bit period and framing-error pulse.
// Optional glitch filter in swo_line_filter is selected by SWO_GLITCH_FILTER_EN.
module swo_uart_rx
  import swo_uart_rx_pkg::*;
#(
  parameter int pDIV_WIDTH = 16
) (
  input  logic                  fe_clk,
  input  logic                  reset,
  input  logic                  I_swo,
  input  logic                  I_enable,
  input  logic [pDIV_WIDTH-1:0] I_baud_div,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_framing_error,
  output logic                  O_busy
);

  localparam logic [pDIV_WIDTH-1:0] MIN_DIV = pDIV_WIDTH'(SWO_MIN_DIV);

  logic                  line_s;
  logic                  line_prev_r;
  logic [2:0]            state_r;
  logic [pDIV_WIDTH-1:0] dl_r;
  logic [pDIV_WIDTH-1:0] cnt_r;
  logic [2:0]            bit_idx_r;
  logic [7:0]            shift_r;
  logic [pDIV_WIDTH-1:0] div_clamped_s;

  assign div_clamped_s = (I_baud_div < MIN_DIV) ? MIN_DIV : I_baud_div;

  swo_line_filter u_line_filter (
    .fe_clk (fe_clk),
    .reset  (reset),
    .I_swo  (I_swo),
    .line   (line_s)
  );

  // Frame FSM: every sample point is reached by counting cnt down to zero.
  always_ff @(posedge fe_clk) begin
    if (reset) begin
      line_prev_r     <= 1'b1;
      state_r         <= SWO_ST_IDLE;
      dl_r            <= MIN_DIV;
      cnt_r           <= '0;
      bit_idx_r       <= 3'd0;
      shift_r         <= 8'h00;
      O_data          <= 8'h00;
      O_data_valid    <= 1'b0;
      O_framing_error <= 1'b0;
      O_busy          <= 1'b0;
    end else begin
      line_prev_r     <= line_s;
      O_data_valid    <= 1'b0;
      O_framing_error <= 1'b0;
      O_busy          <= (state_r != SWO_ST_IDLE);
      if (!I_enable) begin
        state_r <= SWO_ST_IDLE;
        cnt_r   <= '0;
      end else begin
        case (state_r)
          SWO_ST_IDLE: begin
            if (line_prev_r && !line_s) begin
              dl_r    <= div_clamped_s;
              cnt_r   <= div_clamped_s >> 1;
              state_r <= SWO_ST_START;
            end
          end
          SWO_ST_START: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - pDIV_WIDTH'(1);
            end else if (!line_s) begin
              cnt_r     <= dl_r;
              bit_idx_r <= 3'd0;
              state_r   <= SWO_ST_DATA;
            end else begin
              state_r <= SWO_ST_IDLE;
            end
          end
          SWO_ST_DATA: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - pDIV_WIDTH'(1);
            end else begin
              shift_r <= {line_s, shift_r[7:1]};
              cnt_r   <= dl_r;
              if (bit_idx_r == 3'd7) begin
                state_r <= SWO_ST_STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end
          end
          SWO_ST_STOP: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - pDIV_WIDTH'(1);
            end else if (line_s) begin
              O_data       <= shift_r;
              O_data_valid <= 1'b1;
              state_r      <= SWO_ST_IDLE;
            end else begin
              O_framing_error <= 1'b1;
              state_r         <= SWO_ST_WAIT_IDLE;
            end
          end
          SWO_ST_WAIT_IDLE: begin
            // A held-low line (break) must go high before another start edge counts.
            if (line_s) begin
              state_r <= SWO_ST_IDLE;
            end
          end
          default: begin
            state_r <= SWO_ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swo_uart_rx.sv
// Self-checking bench for swo_uart_rx: pin waveforms are built per cycle and a reference
// model derives expected pulses and busy from the frame sample-time formulas.
module tb_swo_uart_rx;

  localparam int W    = 16;
  localparam int MAXC = 4096;
`ifdef SWO_GLITCH_FILTER_EN
  localparam int LAT = 4;
  localparam logic [7:0] GLITCH_EXP = 8'h96;
`else
  localparam int LAT = 2;
  localparam logic [7:0] GLITCH_EXP = 8'h69;
`endif

  logic         fe_clk = 1'b0;
  logic         reset = 1'b1;
  logic         I_swo = 1'b1;
  logic         I_enable = 1'b1;
  logic [W-1:0] I_baud_div = 16'd9;
  logic [7:0]   O_data;
  logic         O_data_valid;
  logic         O_framing_error;
  logic         O_busy;

  swo_uart_rx #(.pDIV_WIDTH(W)) dut (
    .fe_clk          (fe_clk),
    .reset           (reset),
    .I_swo           (I_swo),
    .I_enable        (I_enable),
    .I_baud_div      (I_baud_div),
    .O_data          (O_data),
    .O_data_valid    (O_data_valid),
    .O_framing_error (O_framing_error),
    .O_busy          (O_busy)
  );

  always #5 fe_clk = ~fe_clk;

  int checks = 0;
  int errors = 0;

  bit          wave[MAXC];
  int          div[MAXC];
  logic        busy_obs[MAXC];
  bit          busy_exp[MAXC];
  int          wp;
  int          dis_kind;   // 0 none, 1 reset pulse, 2 enable drop
  int          dis_at;
  int          snap_at;
  logic [7:0]  snap_data;
  logic [2:0]  snap_flags;
  logic [31:0] obs[$];
  logic [31:0] exp_q[$];
  int          nb;

  function automatic logic [31:0] pack_ev(input int c, input int kind, input logic [7:0] d);
    return {c[19:0], 4'(kind), d};
  endfunction

  function automatic bit wv(input int i);
    if (i < 0 || i >= wp) return 1'b1;
    if (dis_kind != 0 && i < dis_at) return 1'b1;
    return wave[i];
  endfunction

  // Line value as seen by the receiver on cycle m.
  function automatic bit lval(input int m);
`ifdef SWO_GLITCH_FILTER_EN
    int s;
    s = int'(wv(m - 3)) + int'(wv(m - 4)) + int'(wv(m - 5));
    return s >= 2;
`else
    return wv(m - LAT);
`endif
  endfunction

  task automatic new_wave();
    wp = 0; dis_kind = 0; dis_at = 0; snap_at = -1;
  endtask

  task automatic put(input bit v, input int n, input int d);
    for (int i = 0; i < n; i++) begin
      if (wp < MAXC) begin
        wave[wp] = v; div[wp] = d; wp++;
      end
    end
  endtask

  task automatic put_frame(input logic [7:0] b, input int d, input bit stop_ok);
    int w;
    w = ((d < 3) ? 3 : d) + 1;
    put(1'b0, w, d);
    for (int k = 0; k < 8; k++) put(b[k], w, d);
    put(stop_ok, w, d);
  endtask

  // Expected pulses and busy trace from the frame timing rules.
  task automatic run_model();
    int m, e, dl, ts, tp, endc;
    logic [7:0] b;
    exp_q.delete();
    for (int c = 0; c < MAXC; c++) busy_exp[c] = 1'b0;
    m = 1;
    while (m < wp) begin
      if (lval(m - 1) && !lval(m)) begin
        dl = (div[m] < 3) ? 3 : div[m];
        ts = m + 1 + dl / 2;
        if (lval(ts)) begin
          endc = ts;
        end else begin
          b = 8'h00;
          for (int k = 0; k < 8; k++) b[k] = lval(ts + (k + 1) * (dl + 1));
          tp = ts + 9 * (dl + 1);
          if (lval(tp)) begin
            exp_q.push_back(pack_ev(tp + 1, 1, b));
            endc = tp;
          end else begin
            exp_q.push_back(pack_ev(tp + 1, 2, 8'h00));
            e = tp + 1;
            while (!lval(e) && e < MAXC) e++;
            endc = e;
          end
        end
        for (int c = m + 1; c <= endc && c + 1 < MAXC; c++) busy_exp[c + 1] = 1'b1;
        m = endc + 1;
      end else begin
        m++;
      end
    end
  endtask

  task automatic run_wave(input bit init_rst);
    obs.delete();
    if (init_rst) begin
      reset = 1'b1; I_swo = 1'b1; I_enable = 1'b1;
      repeat (3) @(posedge fe_clk);
    end else begin
      @(posedge fe_clk);
    end
    for (int k = 0; k < wp; k++) begin
      #1;
      reset      = (dis_kind == 1 && k >= dis_at && k < dis_at + 5);
      I_enable   = !(dis_kind == 2 && k >= dis_at && k < dis_at + 5);
      I_swo      = wave[k];
      I_baud_div = W'(div[k]);
      @(negedge fe_clk);
      busy_obs[k] = O_busy;
      if (O_data_valid) obs.push_back(pack_ev(k, 1, O_data));
      if (O_framing_error) obs.push_back(pack_ev(k, 2, 8'h00));
      if (k == snap_at) begin
        snap_data = O_data; snap_flags = {O_data_valid, O_framing_error, O_busy};
      end
      @(posedge fe_clk);
    end
    #1;
    reset = 1'b0; I_enable = 1'b1; I_swo = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; I_swo = 1'b0;
    repeat (3) @(posedge fe_clk);
    @(negedge fe_clk);
    checks++; if (O_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", O_data); end
    checks++; if (O_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", O_data_valid); end
    checks++; if (O_framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, expected 0", O_framing_error); end
    checks++; if (O_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", O_busy); end
    I_swo = 1'b1;
  endtask

  task automatic test_basic();
    new_wave();
    put(1'b1, 10, 9); put_frame(8'hA5, 9, 1'b1); put(1'b1, 40, 9);
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d, expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
    checks++; if (obs.size() != 1 || obs[0] !== pack_ev(10 + LAT + 96, 1, 8'hA5)) begin errors++; $display("FAIL basic_a5_time: got %0d events first %h, expected %h", obs.size(), (obs.size() > 0) ? obs[0] : 32'h0, pack_ev(10 + LAT + 96, 1, 8'hA5)); end
    nb = 0; for (int c = 0; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL basic_busy: %0d cycles differ, expected 0", nb); end
  endtask

  task automatic test_framing_error();
    new_wave();
    put(1'b1, 10, 9); put_frame(8'h3C, 9, 1'b0); put(1'b0, 90, 9);
    put(1'b1, 30, 9); put_frame(8'h81, 9, 1'b1); put(1'b1, 40, 9);
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL ferr_count: got %0d, expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL ferr_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
    checks++; if (obs.size() != 2 || obs[0][11:0] !== 12'h200 || obs[1][11:0] !== 12'h181) begin errors++; $display("FAIL ferr_sequence: got %0d events, expected error then valid 81", obs.size()); end
    nb = 0; for (int c = 0; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL ferr_busy: %0d cycles differ, expected 0", nb); end
  endtask

  task automatic test_false_start();
    new_wave();
    put(1'b1, 10, 9); put(1'b0, 3, 9); put(1'b1, 40, 9);
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != 0) begin errors++; $display("FAIL false_start_events: got %0d, expected 0", obs.size()); end
    checks++; if (busy_obs[wp - 1] !== 1'b0) begin errors++; $display("FAIL false_start_busy_end: got %b, expected 0", busy_obs[wp - 1]); end
    nb = 0; for (int c = 0; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL false_start_busy: %0d cycles differ, expected 0", nb); end
  endtask

  task automatic test_baud_change();
    new_wave();
    put(1'b1, 10, 9); put_frame(8'h55, 9, 1'b1);
    for (int i = 60; i < wp; i++) div[i] = 19;
    put(1'b1, 30, 19); put_frame(8'hF0, 19, 1'b1); put(1'b1, 50, 19);
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL baud_count: got %0d, expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL baud_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
    checks++; if (obs.size() != 2 || obs[0][11:0] !== 12'h155 || obs[1][11:0] !== 12'h1F0) begin errors++; $display("FAIL baud_bytes: got %0d events, expected 55 then F0", obs.size()); end
    nb = 0; for (int c = 0; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL baud_busy: %0d cycles differ, expected 0", nb); end
  endtask

  task automatic test_reset_midframe();
    new_wave();
    put(1'b1, 10, 9); put_frame(8'hE7, 9, 1'b1);
    wp = 65; dis_kind = 1; dis_at = 65; snap_at = 68;
    put(1'b1, 40, 9); put_frame(8'h12, 9, 1'b1); put(1'b1, 40, 9);
    run_model(); run_wave(1'b0);
    checks++; if (snap_data !== 8'h00 || snap_flags !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got data %h flags %b, expected 00 000", snap_data, snap_flags); end
    checks++; if (obs.size() != 1 || obs[0][11:0] !== 12'h112) begin errors++; $display("FAIL rst_mid_next: got %0d events, expected single valid 12", obs.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
    nb = 0; for (int c = dis_at + 7; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL rst_mid_busy: %0d cycles differ, expected 0", nb); end
  endtask

  task automatic test_enable_drop();
    logic [7:0] b;
    b = 8'($urandom);
    new_wave();
    put(1'b1, 10, 9); put_frame(8'h5A, 9, 1'b1);
    wp = 55; dis_kind = 2; dis_at = 55;
    put(1'b1, 40, 9); put_frame(b, 9, 1'b1); put(1'b1, 40, 9);
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != exp_q.size() || obs.size() != 1) begin errors++; $display("FAIL enable_count: got %0d, expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL enable_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
    nb = 0; for (int c = dis_at + 7; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL enable_busy: %0d cycles differ, expected 0", nb); end
  endtask

  task automatic test_glitch();
    new_wave();
    put(1'b1, 10, 15); put_frame(8'h96, 15, 1'b1); put(1'b1, 40, 15);
    for (int k = 0; k < 8; k++) wave[10 + 16 * (k + 1) + 8] = ~wave[10 + 16 * (k + 1) + 8];
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != 1 || obs[0][11:0] !== {4'd1, GLITCH_EXP}) begin errors++; $display("FAIL glitch_byte: got %0d events first %h, expected valid %h", obs.size(), (obs.size() > 0) ? obs[0] : 32'h0, GLITCH_EXP); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
  endtask

  task automatic test_back_to_back_random();
    int d, w;
    bit bad;
    new_wave();
    put(1'b1, 10, 9);
    for (int f = 0; f < 8; f++) begin
      d = $urandom_range(0, 20);
      w = ((d < 3) ? 3 : d) + 1;
      bad = ($urandom_range(0, 4) == 0);
      put_frame(8'($urandom), d, !bad);
      if (bad) put(1'b1, w, d);
      put(1'b1, $urandom_range(0, 12), d);
    end
    put(1'b1, 60, 20);
    run_model(); run_wave(1'b1);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d, expected %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL random_ev%0d: got %h, expected %h", i, obs[i], exp_q[i]); end end
    nb = 0; for (int c = 0; c < wp; c++) if (busy_obs[c] !== busy_exp[c]) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL random_busy: %0d cycles differ, expected 0", nb); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_framing_error();
    test_false_start();
    test_baud_change();
    test_reset_midframe();
    test_enable_drop();
    test_glitch();
    test_back_to_back_random();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
